ifetch: RTL

Instruction-fetch stage for the single-issue RISC-V core, directly downstream of the PC controller. It takes the current `pc`, runs a request/grant/response handshake with instruction memory, and holds the fetched word for decode/execute. It drives the PC controller's `stay` input so `pc` advances only once per completed, consumed instruction.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_timer.sv | 29 ++
 rtl/ifetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } ifetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_timer.sv
// WAIT-phase watchdog: clears on load, counts while asked, flags the cycle that reaches LIMIT.
module ifetch_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Fires on the counting cycle whose increment would reach LIMIT.
  assign o_expire = i_count && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: req/gnt/rvalid handshake with imem, holds one word, drives PC-controller stay.
// Optional WAIT timeout fault is built only when IFETCH_TIMEOUT_EN is defined.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        exec_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stay,
  output logic        fetch_fault
);

  ifetch_state_t r_state;
  logic [31:0]   r_instr;
  logic          r_instr_valid;
  logic          r_fault;
  logic          w_misaligned;
  logic          w_timeout;

  assign w_misaligned = (pc[1:0] != 2'b00);

`ifdef IFETCH_TIMEOUT_EN
  logic w_tmr_clear;
  logic w_tmr_count;

  assign w_tmr_clear = (r_state == REQ) && imem_gnt && !w_misaligned;
  assign w_tmr_count = (r_state == WAIT) && !imem_rvalid;

  ifetch_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (w_tmr_clear),
    .i_count  (w_tmr_count),
    .o_expire (w_timeout)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_instr       <= INSTR_NOP;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_misaligned) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (imem_gnt) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Responses are only ever sampled here; anything else is stale.
          if (imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= HOLD;
          end else if (w_timeout) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end
        end
        HOLD: begin
          if (!exec_stall) begin
            r_instr_valid <= 1'b0;
            r_state       <= REQ;
          end
        end
        FAULT:   r_state <= FAULT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == REQ) && !w_misaligned;
  assign imem_addr   = (r_state == REQ) ? {pc[31:2], 2'b00} : 32'h0;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_fault = r_fault;
  // PC may move only on the HOLD cycle the consumer accepts the word.
  assign stay        = !((r_state == HOLD) && !exec_stall);

endmodule
